seg_disp_sched: RTL and testbench
=================================

# seg_disp_sched

Time-multiplexing scheduler that shares the four-digit seven-segment display between several requesters. Each requester asks for the display with a level request. The block grants one requester at a time, round-robin, for a fixed dwell period and forwards that requester's 16-bit hex value to the display driver's `data_in`. It sits between the application blocks (counters, status, debug) and the seven-segment display driver, in the 50 MHz domain.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DWELL`, 50_000_000: cycles per display slot (1 s at 50 MHz); must be ≥ 2.
- `CNT_W`, 26: dwell counter width; must satisfy 2^CNT_W > DWELL.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  level request per requester.
- `req_data`  in  16*NREQ  hex value of requester i, in bits [16i+15:16i].
- `gnt`  out  NREQ  one-hot grant, registered.
- `done`  out  NREQ  one-cycle pulse on the final cycle of a completed slot.
- `disp_data`  out  16  value for the display driver's `data_in`.
- `disp_src`  out  3  index of the granted (or last granted) requester.
- `disp_valid`  out  1  high while any grant is active.

## Operation
- Reset values:
  - `gnt`=0, `done`=0, `disp_data`=16'h0000, `disp_src`=0, `disp_valid`=0.
  - Dwell counter = 0, state IDLE.
  - Round-robin pointer `last` = NREQ-1, so requester 0 wins first.
- States: IDLE and SHOW.
- IDLE:
  - With `req`≠0: pick the first set bit of `req` searching from `last`+1 upward, wrapping modulo NREQ.
  - Register `gnt`, `disp_src` and `last` to the winner, clear the counter, go to SHOW.
- SHOW:
  - `disp_data` follows `req_data` of the granted source every cycle, so live values display.
  - The counter increments each cycle.
- Normal end of slot (counter = DWELL-1 with the granted `req` still high):
  - `done[src]`=1 on that cycle.
  - Re-arbitrate the same cycle using the current `req`, with `last` = src.
  - If a winner exists, the new grant starts on the next cycle with no gap; the same source may win again if it is the only requester.
  - If no winner, go to IDLE.
- Early release: the granted `req` drops mid-slot.
  - The slot ends; `gnt` clears on the next cycle.
  - No `done` pulse.
  - Re-arbitration follows the same rule as a normal end.
- IDLE display:
  - `disp_valid`=0 and `gnt`=0.
  - `disp_data` and `disp_src` hold their last values, so the display keeps the last number.
- Requests that rise and fall while another source holds the grant are never seen; no latching.
- `req_data` changing on a non-granted source has no effect.
- Asynchronous reset asserted mid-slot:
  - All outputs and state return to reset values immediately.
  - A `done` pulse in progress is lost.

## Timing
- Latency: `req` rising in IDLE at edge t gives `gnt` and `disp_valid` high after edge t+1.
- `disp_data` is valid in the same cycle as `gnt`.
- A completed slot holds `gnt` high for exactly DWELL cycles. `done` coincides with the last of them.
- Back-to-back slots: `gnt` changes one-hot value across a single edge and is never 0 in between.
- `disp_data` lags `req_data` of the granted source by one register stage.
- All outputs are registered.

## Configuration
- Macro: `SEG_SCHED_PREEMPT_EN`.
- Defined: requester 0 is urgent.
  - `req[0]` rising while another source is in SHOW ends that slot; the preempted source gets no `done`.
  - `gnt`=1<<0 from the next cycle, and the counter restarts.
  - `last` is not updated to 0 by a preemption grant, so the preempted source's round-robin turn is preserved.
  - Source 0 cannot be preempted by itself.
- Undefined: requester 0 is an ordinary round-robin participant, and no slot ends before DWELL cycles except on early release.

## Structure
- Package `seg_disp_pkg` holds:
  - `DIGITS`=4 and `HEX_W`=16.
  - The `NREQ`/`DWELL` defaults.
  - The state enum `sched_state_t` {IDLE, SHOW}.
- Sub-module `seg_rr_pick` is purely combinational.
  - Inputs: request vector and `last`.
  - Outputs: one-hot winner, index and `any`.
  - Instantiated once.

## Test plan
All scenarios use DWELL=4 and NREQ=4.
- Reset, then `req`=4'b0001 with data0=16'h1234 → `gnt`=0001 two edges later, `disp_data`=16'h1234, `done[0]` on the 4th grant cycle, then re-grant to 0 with no gap.
- `req`=4'b1011 held → grant order 0,1,3,0,…; each slot lasts 4 cycles; one `done` per slot.
- Source 1 granted, `req[1]` dropped after 2 cycles → `gnt`=0 next cycle, no `done[1]`, `disp_valid`=0, `disp_data` keeps the last value.
- Granted source's `req_data` stepping 16'h0001→16'h0002 mid-slot → `disp_data` updates one cycle later; `gnt` is unaffected.
- `rst` pulsed mid-slot (asynchronous, between edges) → all outputs zero immediately; the first grant afterwards goes to source 0.
- With `SEG_SCHED_PREEMPT_EN`, source 2 granted and `req[0]` rising at slot cycle 1 → `gnt`=0001 next cycle, no `done[2]`; after source 0's slot, source 2 is granted before source 3.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared constants and types for the seven-segment display scheduler.
// Contents: display geometry (DIGITS, HEX_W), default NREQ/DWELL/CNT_W, FSM state type.
package seg_disp_pkg;
    localparam int DIGITS    = 4;
    localparam int HEX_W     = 16;
    localparam int NREQ_DEF  = 4;
    localparam int DWELL_DEF = 50_000_000;
    localparam int CNT_W_DEF = 26;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } sched_state_t;
endpackage

// File: rtl/seg_disp_sched_if.sv
// seg_disp_sched_if: requester/display bundle around the display scheduler.
// Signals: req, req_data (requesters -> scheduler); gnt, done, disp_data, disp_src,
// disp_valid (scheduler -> requesters and display driver).
// Modports: master = requester/driver side, slave = scheduler side.
interface seg_disp_sched_if
    import seg_disp_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
);
    logic [NREQ-1:0]       req;
    logic [HEX_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [HEX_W-1:0]      disp_data;
    logic [2:0]            disp_src;
    logic                  disp_valid;

    modport master (
        output req, req_data,
        input  gnt, done, disp_data, disp_src, disp_valid
    );

    modport slave (
        input  req, req_data,
        output gnt, done, disp_data, disp_src, disp_valid
    );
endinterface

// File: rtl/seg_disp_sched_rr_pick.sv
// seg_rr_pick: combinational round-robin picker.
// Ports: req (request vector), last (previous winner) in;
//        win (one-hot), win_idx (index), any (a winner exists) out.
// Search starts at last+1 and wraps modulo NREQ.
module seg_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last,
    output logic [NREQ-1:0] win,
    output logic [2:0]      win_idx,
    output logic            any
);
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        // First pass covers indices above last, second pass the wrapped part.
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i > int'(last))) begin
                any     = 1'b1;
                win[i]  = 1'b1;
                win_idx = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i <= int'(last))) begin
                any     = 1'b1;
                win[i]  = 1'b1;
                win_idx = 3'(i);
            end
        end
    end
endmodule

// File: rtl/seg_disp_sched.sv
// seg_disp_sched: shares the four-digit seven-segment display between NREQ requesters,
// round-robin, one fixed dwell slot (DWELL cycles) per grant.
// Ports: clk, rst (asynchronous, active-high), bus (slave modport of seg_disp_sched_if).
// Build option: SEG_SCHED_PREEMPT_EN makes requester 0 urgent -- a rising req[0]
// ends another source's slot and takes the display without moving the RR pointer.
//
// state | meaning
// IDLE  | no grant; display holds the last value
// SHOW  | one source granted, dwell counter running
module seg_disp_sched
    import seg_disp_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DWELL = DWELL_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    seg_disp_sched_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    sched_state_t     state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       last, last_nx;
    logic [NREQ-1:0]  gnt_nx, done_nx;
    logic [2:0]       src_nx;
    logic [HEX_W-1:0] data_nx;
    logic [2:0]       pick_last;
    logic [NREQ-1:0]  pick_win;
    logic [2:0]       pick_idx;
    logic             pick_any;
    logic             granted_req;
    logic             rearb;
`ifdef SEG_SCHED_PREEMPT_EN
    logic             req0_q;
`endif

    // At the end of a slot the search restarts after the source that just showed.
    assign pick_last   = (state == SHOW) ? bus.disp_src : last;
    assign granted_req = |(bus.gnt & bus.req);

    seg_rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (bus.req),
        .last    (pick_last),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        gnt_nx   = bus.gnt;
        src_nx   = bus.disp_src;
        rearb    = 1'b0;
        case (state)
            IDLE: rearb = 1'b1;
            SHOW: begin
                if (!granted_req || (cnt == CNT_LAST)) begin
                    rearb = 1'b1;
                end
`ifdef SEG_SCHED_PREEMPT_EN
                else if ((bus.disp_src != 3'd0) && bus.req[0] && !req0_q) begin
                    gnt_nx = {{(NREQ-1){1'b0}}, 1'b1};
                    src_nx = 3'd0;
                    cnt_nx = '0;
                end
`endif
                else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: rearb = 1'b1;
        endcase
        if (rearb) begin
            if (pick_any) begin
                state_nx = SHOW;
                gnt_nx   = pick_win;
                src_nx   = pick_idx;
                last_nx  = pick_idx;
                cnt_nx   = '0;
            end else begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        end
        // done is registered, so it is raised on entry to the final slot cycle.
        done_nx = ((state_nx == SHOW) && (cnt_nx == CNT_LAST)) ? gnt_nx : '0;
        data_nx = bus.disp_data;
        if (state_nx == SHOW) begin
            data_nx = bus.req_data[int'(src_nx)*HEX_W +: HEX_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            last           <= 3'(NREQ - 1);
            bus.gnt        <= '0;
            bus.done       <= '0;
            bus.disp_data  <= '0;
            bus.disp_src   <= '0;
            bus.disp_valid <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            last           <= last_nx;
            bus.gnt        <= gnt_nx;
            bus.done       <= done_nx;
            bus.disp_data  <= data_nx;
            bus.disp_src   <= src_nx;
            bus.disp_valid <= (state_nx == SHOW);
        end
    end

`ifdef SEG_SCHED_PREEMPT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req0_q <= 1'b0;
        end else begin
            req0_q <= bus.req[0];
        end
    end
`endif
endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched: self-checking bench for seg_disp_sched (NREQ=4, DWELL=4).
// Expected output words {gnt,done,disp_valid,disp_src,disp_data} are queued as each
// cycle's stimulus is applied and popped for comparison after the clock edge.
module tb_seg_disp_sched;
    import seg_disp_pkg::*;

    localparam int NREQ  = 4;
    localparam int DWELL = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_disp_sched_if #(.NREQ(NREQ)) bus ();

    seg_disp_sched #(.NREQ(NREQ), .DWELL(DWELL), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_run  = 0;
    int          n_fail = 0;
    logic [27:0] sb[$];
    logic [27:0] obs;
    logic [27:0] e;

    assign obs = {bus.gnt, bus.done, bus.disp_valid, bus.disp_src, bus.disp_data};

    function automatic logic [27:0] ex(logic [3:0] g, logic [3:0] d, logic v,
                                       logic [2:0] s, logic [15:0] dat);
        return {g, d, v, s, dat};
    endfunction

    function automatic logic [15:0] dval(int i);
        case (i)
            0:       return 16'h1234;
            1:       return 16'h1111;
            2:       return 16'h2222;
            default: return 16'h3333;
        endcase
    endfunction

    task automatic apply_reset();
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = {16'h3333, 16'h2222, 16'h1111, 16'h1234};
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req      = '0;
        bus.req_data = {16'h3333, 16'h2222, 16'h1111, 16'h1234};
        for (int c = 0; c < 4; c++) begin
            if (c == 2) rst = 1'b0;
            sb.push_back(ex(4'b0000, 4'b0000, 1'b0, 3'd0, 16'h0000));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d] got %h exp %h", c, obs, e);
            end
        end
    endtask

    task automatic test_single();
        apply_reset();
        bus.req = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            sb.push_back(ex(4'b0001, (c % 4 == 3) ? 4'b0001 : 4'b0000, 1'b1, 3'd0, 16'h1234));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL single[%0d] got %h exp %h", c, obs, e);
            end
        end
        bus.req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            sb.push_back(ex(4'b0000, 4'b0000, 1'b0, 3'd0, 16'h1234));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL single_idle[%0d] got %h exp %h", c, obs, e);
            end
        end
    endtask

    task automatic test_round_robin();
        int         ord[4] = '{0, 1, 3, 0};
        logic [3:0] oh;
        apply_reset();
        bus.req = 4'b1011;
        for (int c = 0; c < 16; c++) begin
            oh = 4'b0001 << ord[c / 4];
            sb.push_back(ex(oh, (c % 4 == 3) ? oh : 4'b0000, 1'b1, 3'(ord[c / 4]),
                            dval(ord[c / 4])));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL round_robin[%0d] got %h exp %h", c, obs, e);
            end
        end
    endtask

    task automatic test_early_release();
        apply_reset();
        bus.req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) bus.req = 4'b0000;
            if (c < 2) sb.push_back(ex(4'b0010, 4'b0000, 1'b1, 3'd1, 16'h1111));
            else       sb.push_back(ex(4'b0000, 4'b0000, 1'b0, 3'd1, 16'h1111));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL early_release[%0d] got %h exp %h", c, obs, e);
            end
        end
    endtask

    task automatic test_live_data();
        apply_reset();
        bus.req                 = 4'b0100;
        bus.req_data[47:32]     = 16'h0001;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                bus.req_data[47:32] = 16'h0002;
                bus.req_data[63:48] = 16'hffff;
            end
            sb.push_back(ex(4'b0100, (c == 3) ? 4'b0100 : 4'b0000, 1'b1, 3'd2,
                            (c == 0) ? 16'h0001 : 16'h0002));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL live_data[%0d] got %h exp %h", c, obs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.req = 4'b1011;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) sb.push_back(ex(4'b0001, (c == 3) ? 4'b0001 : 4'b0000, 1'b1, 3'd0, 16'h1234));
            else       sb.push_back(ex(4'b0010, 4'b0000, 1'b1, 3'd1, 16'h1111));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL async_pre[%0d] got %h exp %h", c, obs, e);
            end
        end
        #2 rst = 1'b1;
        sb.push_back(ex(4'b0000, 4'b0000, 1'b0, 3'd0, 16'h0000));
        #1;
        e = sb.pop_front();
        n_run++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_immediate got %h exp %h", obs, e);
        end
        sb.push_back(ex(4'b0000, 4'b0000, 1'b0, 3'd0, 16'h0000));
        @(posedge clk); #1;
        e = sb.pop_front();
        n_run++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_held got %h exp %h", obs, e);
        end
        rst = 1'b0;
        sb.push_back(ex(4'b0001, 4'b0000, 1'b1, 3'd0, 16'h1234));
        @(posedge clk); #1;
        e = sb.pop_front();
        n_run++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_first_grant got %h exp %h", obs, e);
        end
    endtask

`ifdef SEG_SCHED_PREEMPT_EN
    task automatic test_preempt();
        apply_reset();
        bus.req = 4'b1100;
        for (int c = 0; c < 7; c++) begin
            if (c == 2) bus.req = 4'b1101;
            if (c < 2 || c == 6) sb.push_back(ex(4'b0100, 4'b0000, 1'b1, 3'd2, 16'h2222));
            else sb.push_back(ex(4'b0001, (c == 5) ? 4'b0001 : 4'b0000, 1'b1, 3'd0, 16'h1234));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL preempt[%0d] got %h exp %h", c, obs, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_live_data();
        test_async_reset();
`ifdef SEG_SCHED_PREEMPT_EN
        test_preempt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
